// File: rtl/magic_button_ctrl_pkg.sv
// Shared types and constants for the magic button / hotkey front end.
package magic_button_ctrl_pkg;

    localparam int unsigned CLK28_HZ = 28_000_000;

    typedef enum logic [2:0] {
        BTN_ARMWAIT,
        BTN_IDLE,
        BTN_PRESSED,
        BTN_LONGHELD,
        BTN_PENDING
    } btnctl_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/magic_button_ctrl_debounce.sv
// Two-flop synchronizer plus tick-based stability filter for an active-low raw input.
module magic_button_ctrl_debounce #(
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw_n,
    output logic o_sync,
    output logic o_level
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS);

    logic          r_meta_n;
    logic          r_sync_n;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_sync;

    assign w_sync  = ~r_sync_n;
    assign o_sync  = w_sync;
    assign o_level = r_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta_n <= 1'b1;
            r_sync_n <= 1'b1;
        end else begin
            r_meta_n <= i_raw_n;
            r_sync_n <= r_meta_n;
        end
    end

    // The first tick only opens the window, so STABLE_TICKS full ms must follow it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/magic_button_ctrl.sv
// Turns the MAGIC button and keyboard hotkeys into magic_button / reboot_req requests.
module magic_button_ctrl
    import magic_button_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV    = CLK28_HZ / 1000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned PENDING_MS  = 100
) (
    input  logic clk28,
    input  logic rst,
    input  logic btn_n_raw,
    input  logic key_magic,
    input  logic key_reboot,
    input  logic n_int,
    input  logic n_int_next,
    output logic magic_button,
    output logic reboot_req,
    output logic btn_pressed
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned MW = $clog2(max_u(max_u(LONG_MS, PENDING_MS), DEBOUNCE_MS) + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MS_SAT    = '1;
    localparam logic [MW-1:0] MS_LONG   = MW'(LONG_MS);
    localparam logic [MW-1:0] MS_PEND   = MW'(PENDING_MS);
    localparam logic [MW-1:0] MS_ARM    = MW'(DEBOUNCE_MS);

    btnctl_state_t r_state;
    btnctl_state_t w_next;
    logic [TW-1:0] r_tick_cnt;
    logic [MW-1:0] r_hold_ms;
    logic [MW-1:0] r_pend_ms;
    logic          r_btn_d;
    logic          r_magic;
    logic          r_reboot;
    logic          w_tick;
    logic          w_btn;
    logic          w_sync;
    logic          w_rise;
    logic          w_edge_int;
    logic          w_reboot;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst)         r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    magic_button_ctrl_debounce #(
        .STABLE_TICKS (DEBOUNCE_MS)
    ) u_debounce (
        .i_clk   (clk28),
        .i_rst   (rst),
        .i_tick  (w_tick),
        .i_raw_n (btn_n_raw),
        .o_sync  (w_sync),
        .o_level (w_btn)
    );

    assign w_rise     = w_btn & ~r_btn_d;
    assign w_edge_int = n_int & ~n_int_next;

    // ARMWAIT leaves only after a full debounce window of confirmed release, so a
    // button held through reset (still inside the synchronizer) is not taken as idle.
    always_comb begin
        w_next   = r_state;
        w_reboot = 1'b0;
        case (r_state)
            BTN_ARMWAIT:  if (!w_btn && !w_sync && r_hold_ms == MS_ARM) w_next = BTN_IDLE;
            BTN_IDLE: begin
                if (key_magic)   w_next = BTN_PENDING;
                else if (w_rise) w_next = BTN_PRESSED;
            end
            BTN_PRESSED: begin
                if (r_hold_ms == MS_LONG) begin
                    w_reboot = 1'b1;
                    w_next   = BTN_LONGHELD;
                end else if (!w_btn) begin
                    w_next = BTN_PENDING;
                end
            end
            BTN_LONGHELD: if (!w_btn) w_next = BTN_IDLE;
            BTN_PENDING:  if (w_edge_int || r_pend_ms == MS_PEND) w_next = BTN_IDLE;
            default:      w_next = BTN_ARMWAIT;
        endcase
        if (key_reboot && r_state != BTN_ARMWAIT) begin
            w_reboot = 1'b1;
            w_next   = BTN_IDLE;
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            r_state  <= BTN_ARMWAIT;
            r_btn_d  <= 1'b0;
            r_magic  <= 1'b0;
            r_reboot <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_btn_d  <= w_btn;
            r_magic  <= (w_next == BTN_PENDING);
            r_reboot <= w_reboot;
        end
    end

    // hold_ms doubles as the release-confirmation timer while in ARMWAIT.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            r_hold_ms <= '0;
        end else if ((r_state != BTN_PRESSED && r_state != BTN_ARMWAIT) ||
                     (r_state == BTN_ARMWAIT && (w_sync || w_btn))) begin
            r_hold_ms <= '0;
        end else if (w_tick && r_hold_ms != MS_SAT) begin
            r_hold_ms <= r_hold_ms + 1'b1;
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst)                                r_pend_ms <= '0;
        else if (r_state != BTN_PENDING)        r_pend_ms <= '0;
        else if (w_tick && r_pend_ms != MS_SAT) r_pend_ms <= r_pend_ms + 1'b1;
    end

    assign magic_button = r_magic;
    assign reboot_req   = r_reboot;
    assign btn_pressed  = w_btn;

endmodule

// File: tb/tb_magic_button_ctrl.sv
// Directed bench for magic_button_ctrl with a cycle-level reference model of the request rules.
module tb_magic_button_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LM = 20;
    localparam int PM = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n_raw = 1'b1;
    logic key_magic = 1'b0;
    logic key_reboot = 1'b0;
    logic n_int = 1'b1;
    logic n_int_next = 1'b1;
    logic magic_button;
    logic reboot_req;
    logic btn_pressed;

    int n_checks = 0;
    int n_fail = 0;
    int mag_rises = 0;
    int mag_hi = 0;
    int reboots = 0;
    int btn_rises = 0;
    logic prev_mag = 1'b0;
    logic prev_btn = 1'b0;

    always #5 clk = ~clk;

    magic_button_ctrl #(
        .TICK_DIV    (TD),
        .DEBOUNCE_MS (DB),
        .LONG_MS     (LM),
        .PENDING_MS  (PM)
    ) u_dut (
        .clk28        (clk),
        .rst          (rst),
        .btn_n_raw    (btn_n_raw),
        .key_magic    (key_magic),
        .key_reboot   (key_reboot),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .magic_button (magic_button),
        .reboot_req   (reboot_req),
        .btn_pressed  (btn_pressed)
    );

    // Reference model: cycle index since reset, tick count by arithmetic,
    // request lifetimes kept as entry timestamps (-1 = not active).
    int   m_n, m_run, m_last_bad, m_held, m_pend;
    int   nx_held, nx_pend;
    bit   m_armed, m_long, nx_armed, nx_long;
    bit   m_btn, m_btn_prev, m_raw1, m_raw2, m_nb;
    bit   m_tick, m_sync, m_rise, m_edge, m_reb;
    logic exp_magic = 1'b0;
    logic exp_reboot = 1'b0;
    logic exp_btn = 1'b0;

    function automatic int nticks(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / TD - a / TD;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_n = 0; m_run = -1; m_last_bad = -1; m_held = -1; m_pend = -1;
            m_armed = 1'b0; m_long = 1'b0; m_btn = 1'b0; m_btn_prev = 1'b0;
            m_raw1 = 1'b1; m_raw2 = 1'b1;
            exp_magic = 1'b0; exp_reboot = 1'b0; exp_btn = 1'b0;
        end else begin
            m_tick = ((m_n % TD) == TD - 1);
            m_sync = !m_raw2;
            m_rise = m_btn && !m_btn_prev;
            m_edge = n_int && !n_int_next;
            m_reb = 1'b0;
            nx_armed = m_armed; nx_long = m_long; nx_held = m_held; nx_pend = m_pend;
            if (!m_armed) begin
                if (m_sync || m_btn) m_last_bad = m_n;
                else if (nticks(m_last_bad + 1, m_n - 1) == DB) nx_armed = 1'b1;
            end else begin
                if (m_pend >= 0) begin
                    if (m_edge || nticks(m_pend, m_n - 1) == PM) nx_pend = -1;
                end else if (m_held >= 0) begin
                    if (nticks(m_held, m_n - 1) == LM) begin
                        m_reb = 1'b1; nx_held = -1; nx_long = 1'b1;
                    end else if (!m_btn) begin
                        nx_held = -1; nx_pend = m_n + 1;
                    end
                end else if (m_long) begin
                    if (!m_btn) nx_long = 1'b0;
                end else begin
                    if (key_magic) nx_pend = m_n + 1;
                    else if (m_rise) nx_held = m_n + 1;
                end
                if (key_reboot) begin
                    m_reb = 1'b1; nx_held = -1; nx_long = 1'b0; nx_pend = -1;
                end
            end
            m_nb = m_btn;
            if (m_sync != m_btn) begin
                if (m_run < 0) m_run = m_n;
                if (m_tick && nticks(m_run, m_n) == DB + 1) begin
                    m_nb = m_sync; m_run = -1;
                end
            end else begin
                m_run = -1;
            end
            m_btn_prev = m_btn; m_btn = m_nb;
            m_raw2 = m_raw1; m_raw1 = btn_n_raw;
            m_armed = nx_armed; m_long = nx_long; m_held = nx_held; m_pend = nx_pend;
            exp_magic = (nx_pend >= 0);
            exp_reboot = m_reb;
            exp_btn = m_btn;
            m_n++;
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        chk("magic_button", magic_button, exp_magic);
        chk("reboot_req", reboot_req, exp_reboot);
        chk("btn_pressed", btn_pressed, exp_btn);
        if (magic_button && !prev_mag) mag_rises++;
        if (magic_button) mag_hi++;
        if (reboot_req) reboots++;
        if (btn_pressed && !prev_btn) btn_rises++;
        prev_mag = magic_button;
        prev_btn = btn_pressed;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        mag_rises = 0; mag_hi = 0; reboots = 0; btn_rises = 0;
    endtask

    task automatic int_edge();
        n_int_next = 1'b0;
        @(negedge clk);
        n_int = 1'b0; n_int_next = 1'b1;
        @(negedge clk);
        n_int = 1'b1;
    endtask

    task automatic magic_pulse();
        key_magic = 1'b1;
        @(negedge clk);
        key_magic = 1'b0;
    endtask

    initial begin
        cycles(3);
        chk("rst_magic", magic_button, 1'b0);
        chk("rst_reboot", reboot_req, 1'b0);
        chk("rst_btn", btn_pressed, 1'b0);
        rst = 1'b0;
        cycles(40);

        // 1: bouncy press, short hold, release -> one magic request cleared by edge_int
        clr_counts();
        for (int i = 0; i < 15; i++) begin
            btn_n_raw = i[0];
            cycles(2);
        end
        cycles(60);
        btn_n_raw = 1'b1;
        cycles(30);
        chk("t1_magic_up", magic_button, 1'b1);
        int_edge();
        cycles(2);
        chk("t1_magic_cleared", magic_button, 1'b0);
        chk_int("t1_btn_rises", btn_rises, 1);
        chk_int("t1_magic_rises", mag_rises, 1);
        chk_int("t1_reboots", reboots, 0);

        // 2: long hold -> single reboot, no magic
        clr_counts();
        btn_n_raw = 1'b0;
        cycles(120);
        btn_n_raw = 1'b1;
        cycles(40);
        chk_int("t2_reboots", reboots, 1);
        chk_int("t2_magic_rises", mag_rises, 0);
        chk("t2_btn_released", btn_pressed, 1'b0);

        // 3: held through reset is ignored, a fresh press works
        clr_counts();
        btn_n_raw = 1'b0;
        rst = 1'b1;
        cycles(3);
        chk("t3_rst_btn", btn_pressed, 1'b0);
        rst = 1'b0;
        cycles(40);
        btn_n_raw = 1'b1;
        cycles(60);
        chk_int("t3_ignored_magic", mag_rises, 0);
        chk_int("t3_ignored_reboot", reboots, 0);
        btn_n_raw = 1'b0;
        cycles(30);
        btn_n_raw = 1'b1;
        cycles(30);
        chk("t3_magic_up", magic_button, 1'b1);
        cycles(60);
        chk_int("t3_btn_rises", btn_rises, 2);
        chk_int("t3_magic_rises", mag_rises, 1);

        // 4: hotkey magic with no interrupt -> times out after PENDING_MS ticks
        clr_counts();
        key_magic = 1'b1;
        @(negedge clk);
        key_magic = 1'b0;
        chk("t4_magic_up", magic_button, 1'b1);
        cycles(60);
        chk_range("t4_magic_cycles", mag_hi, 38, 41);
        chk_int("t4_reboots", reboots, 0);

        // 5: reboot hotkey cancels a pending magic request
        clr_counts();
        magic_pulse();
        cycles(3);
        chk("t5_magic_up", magic_button, 1'b1);
        @(negedge clk);
        key_reboot = 1'b1;
        @(posedge clk);
        #2;
        chk("t5_reboot_pulse", reboot_req, 1'b1);
        chk("t5_magic_dropped", magic_button, 1'b0);
        @(negedge clk);
        key_reboot = 1'b0;
        cycles(3);
        chk_int("t5_reboots", reboots, 1);

        // 6: two hotkey requests merge into one, cleared by a single edge_int
        clr_counts();
        magic_pulse();
        cycles(2);
        magic_pulse();
        cycles(3);
        int_edge();
        cycles(2);
        chk("t6_magic_cleared", magic_button, 1'b0);
        chk_int("t6_magic_rises", mag_rises, 1);
        chk_int("t6_reboots", reboots, 0);
        cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
